multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RISC-V core. It sequences the shared datapath (PC, IR, register file, ALU, memory port) through fetch, decode, execute, memory and writeback for one instruction at a time. It drives the datapath mux selects, write enables and the instruction/data memory request handshakes, and counts retired instructions. ALU operation selection is not part of this block; `alu_op_gen` derives it from the IR.

---
 rtl/multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback for one
// instruction at a time and counts retired instructions.
module multicycle_ctrl #(
    parameter int OP_BITS  = 7,
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_BITS-1:0]  opcode,
    input  logic                branch_taken,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                ir_we,
    output logic                pc_we,
    output logic                rf_we,
    output logic [1:0]          alu_a_sel,
    output logic                alu_b_sel,
    output logic [1:0]          pc_sel,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic [CNT_BITS-1:0] instret,
    output logic                trap
);
    localparam logic [OP_BITS-1:0] OPC_OP_IMM   = OP_BITS'(7'b0010011);
    localparam logic [OP_BITS-1:0] OPC_LUI      = OP_BITS'(7'b0110111);
    localparam logic [OP_BITS-1:0] OPC_AUIPC    = OP_BITS'(7'b0010111);
    localparam logic [OP_BITS-1:0] OPC_OP       = OP_BITS'(7'b0110011);
    localparam logic [OP_BITS-1:0] OPC_JAL      = OP_BITS'(7'b1101111);
    localparam logic [OP_BITS-1:0] OPC_JALR     = OP_BITS'(7'b1100111);
    localparam logic [OP_BITS-1:0] OPC_BRANCH   = OP_BITS'(7'b1100011);
    localparam logic [OP_BITS-1:0] OPC_LOAD     = OP_BITS'(7'b0000011);
    localparam logic [OP_BITS-1:0] OPC_STORE    = OP_BITS'(7'b0100011);
    localparam logic [OP_BITS-1:0] OPC_MISC_MEM = OP_BITS'(7'b0001111);
    localparam logic [OP_BITS-1:0] OPC_SYSTEM   = OP_BITS'(7'b1110011);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] instret_q, instret_d;
    logic                op_legal;

    assign op_legal = opcode inside {OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_OP,
                                     OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                     OPC_STORE, OPC_MISC_MEM};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (opcode == OPC_BRANCH || opcode == OPC_MISC_MEM)
                    state_d = S_FETCH;
                else if (opcode == OPC_LOAD || opcode == OPC_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready)
                    state_d = (opcode == OPC_STORE) ? S_FETCH : S_WB;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is asserted so an abandoned
    // instruction cannot write, retire or keep a request open.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        pc_sel    = 2'd0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        trap      = 1'b0;
        instret   = reset ? '0 : instret_q;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_sel = 1'b1;
                        OPC_AUIPC: begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
                        OPC_LUI:   begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
                        default: ;
                    endcase
                    if (opcode == OPC_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end else if (opcode == OPC_MISC_MEM) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OPC_STORE);
                    if (dmem_ready && opcode == OPC_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (opcode == OPC_LOAD)
                        wb_sel = 2'd1;
                    else if (opcode == OPC_JAL || opcode == OPC_JALR)
                        wb_sel = 2'd2;
                    if (opcode == OPC_JAL)
                        pc_sel = 2'd1;
                    else if (opcode == OPC_JALR)
                        pc_sel = 2'd2;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign instret_d = retire ? instret_q + CNT_BITS'(1) : instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected retire
// records, a negedge monitor pops and checks them on every retire pulse.
module tb_multicycle_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          branch_taken = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic [1:0]    alu_a_sel, pc_sel, wb_sel;
    logic          alu_b_sel, retire, trap;
    logic [CW-1:0] instret;

    multicycle_ctrl #(.OP_BITS(7), .CNT_BITS(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .pc_sel(pc_sel), .wb_sel(wb_sel),
        .retire(retire), .instret(instret), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat; int dcyc; int dwe; int rfw; int wbs; int pcs;
        int asel; int bsel; int cnt; string name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_ret(input string name, input int lat, input int dcyc,
                              input int dwe, input int rfw, input int wbs,
                              input int pcs, input int asel, input int bsel);
        exp_t e;
        e.name = name; e.lat = lat; e.dcyc = dcyc; e.dwe = dwe; e.rfw = rfw;
        e.wbs = wbs; e.pcs = pcs; e.asel = asel; e.bsel = bsel; e.cnt = exp_cnt;
        exp_q.push_back(e);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    // Monitor: accumulate per-instruction observations, compare on retire.
    int m_cyc = 0, m_dcyc = 0, m_dwe = 0, m_rfw = 0, m_wbs = 0, m_pcs = 0;
    int m_asel = 0, m_bsel = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cyc = 0; m_dcyc = 0; m_dwe = 0; m_rfw = 0; m_wbs = 0;
                m_pcs = 0; m_asel = 0; m_bsel = 0;
            end else begin
                m_cyc++;
                if (dmem_req) begin m_dcyc++; m_dwe |= int'(dmem_we); end
                if (rf_we) begin m_rfw = 1; m_wbs = int'(wb_sel); end
                if (pc_we) m_pcs = int'(pc_sel);
                m_asel |= int'(alu_a_sel);
                m_bsel |= int'(alu_b_sel);
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk({e.name, "_latency"}, m_cyc, e.lat);
                        chk({e.name, "_dmem_cycles"}, m_dcyc, e.dcyc);
                        chk({e.name, "_dmem_we"}, m_dwe, e.dwe);
                        chk({e.name, "_rf_we"}, m_rfw, e.rfw);
                        chk({e.name, "_wb_sel"}, m_wbs, e.wbs);
                        chk({e.name, "_pc_we_with_retire"}, int'(pc_we), 1);
                        chk({e.name, "_pc_sel"}, m_pcs, e.pcs);
                        chk({e.name, "_alu_a_sel"}, m_asel, e.asel);
                        chk({e.name, "_alu_b_sel"}, m_bsel, e.bsel);
                        chk({e.name, "_instret"}, int'(instret), e.cnt);
                    end
                    $display("retire %s: cycles=%0d instret=%0d", e_name_peek(),
                             m_cyc, instret);
                    m_cyc = 0; m_dcyc = 0; m_dwe = 0; m_rfw = 0; m_wbs = 0;
                    m_pcs = 0; m_asel = 0; m_bsel = 0;
                end
            end
        end
    end

    string last_name = "";
    function automatic string e_name_peek();
        return last_name;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after retire.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic tk, input int dwait);
        int  dcnt = 0;
        bit  done = 0;
        last_name = name;
        opcode = op;
        branch_taken = tk;
        for (int c = 0; c < 40 && !done; c++) begin
            imem_ready = imem_req;
            if (dmem_req) begin
                dmem_ready = (dcnt >= dwait);
                dcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (retire) done = 1;
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_trap(input string name, input logic [6:0] op);
        int  at = -1;
        int  req_seen = 0;
        last_name = name;
        opcode = op;
        for (int c = 0; c < 10 && at < 0; c++) begin
            imem_ready = imem_req;
            #1;
            if (trap) at = c;
            else begin @(posedge clk); #1; end
        end
        imem_ready = 1'b0;
        chk({name, "_trap_cycle"}, at, 2);
        chk({name, "_trap_imem_req"}, int'(imem_req), 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            imem_ready = 1'b1;
            #1;
            if (imem_req || !trap || retire) req_seen = 1;
        end
        imem_ready = 1'b0;
        chk({name, "_trap_absorbing"}, req_seen, 0);
        $display("trap %s: entered at cycle %0d", name, at + 1);
        reset = 1'b1;
        #1;
        chk({name, "_reset_trap_low"}, int'(trap), 0);
        chk({name, "_reset_instret"}, int'(instret), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk({name, "_refetch"}, int'(imem_req), 1);
        chk({name, "_instret_cleared"}, int'(instret), 0);
    endtask

    initial begin
        int seen;
        // Reset phase: every output must be low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_imem_req", int'(imem_req), 0);
        chk("reset_outputs", int'({dmem_req, dmem_we, ir_we, pc_we, rf_we,
            alu_a_sel, alu_b_sel, pc_sel, wb_sel, retire, trap, instret}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("post_reset_imem_req", int'(imem_req), 1);
        $display("reset released: imem_req=%0d", imem_req);

        expect_ret("addi", 4, 0, 0, 1, 0, 0, 0, 1);
        run_instr("addi", 7'b0010011, 1'b0, 0);
        expect_ret("load_w3", 8, 4, 0, 1, 1, 0, 0, 1);
        run_instr("load_w3", 7'b0000011, 1'b0, 3);
        expect_ret("branch_taken", 3, 0, 0, 0, 0, 1, 0, 0);
        run_instr("branch_taken", 7'b1100011, 1'b1, 0);
        expect_ret("branch_not", 3, 0, 0, 0, 0, 0, 0, 0);
        run_instr("branch_not", 7'b1100011, 1'b0, 0);
        expect_ret("jal", 4, 0, 0, 1, 2, 1, 0, 0);
        run_instr("jal", 7'b1101111, 1'b0, 0);
        expect_ret("jalr", 4, 0, 0, 1, 2, 2, 0, 1);
        run_instr("jalr", 7'b1100111, 1'b0, 0);
        expect_ret("store_w0", 4, 1, 1, 0, 0, 0, 0, 1);
        run_instr("store_w0", 7'b0100011, 1'b0, 0);
        expect_ret("store_w2", 6, 3, 1, 0, 0, 0, 0, 1);
        run_instr("store_w2", 7'b0100011, 1'b0, 2);
        expect_ret("lui", 4, 0, 0, 1, 0, 0, 2, 1);
        run_instr("lui", 7'b0110111, 1'b0, 0);
        expect_ret("auipc", 4, 0, 0, 1, 0, 0, 1, 1);
        run_instr("auipc", 7'b0010111, 1'b0, 0);
        expect_ret("op", 4, 0, 0, 1, 0, 0, 0, 0);
        run_instr("op", 7'b0110011, 1'b0, 0);

        run_trap("illegal0", 7'b0000000);
        run_trap("system", 7'b1110011);

        // One instruction so instret is non-zero before the aborted store.
        expect_ret("nop_pre", 3, 0, 0, 0, 0, 0, 0, 0);
        run_instr("nop_pre", 7'b0001111, 1'b0, 0);
        last_name = "store_abort";
        opcode = 7'b0100011;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) seen = 1;
            else begin @(posedge clk); #1; end
        end
        imem_ready = 1'b0;
        chk("store_abort_req_seen", seen, 1);
        @(posedge clk); #1;
        chk("store_abort_req_held", int'(dmem_req), 1);
        reset = 1'b1;
        #1;
        chk("store_abort_req_drop", int'(dmem_req), 0);
        chk("store_abort_no_retire", int'(retire | pc_we), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        chk("store_abort_instret", int'(instret), 0);
        $display("store abort: dmem_req=%0d instret=%0d", dmem_req, instret);

        for (int i = 0; i < 16; i++) begin
            expect_ret("nop_wrap", 3, 0, 0, 0, 0, 0, 0, 0);
            run_instr("nop_wrap", 7'b0001111, 1'b0, 0);
        end
        chk("instret_wrap", int'(instret), 0);
        $display("wrap: instret=%0d after 16 retires", instret);

        @(posedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=1 want=0");
        $fatal(1, "timeout");
    end
endmodule
